// File: rtl/mem_access_unit_if.sv
// Processor-side load/store request and response channel of mem_access_unit.
// The master drives requests and accepts responses; the slave is the unit.
interface mem_access_unit_if;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-addressed data RAM.
// Requests run IDLE -> ISSUE -> RESP; rejected requests skip ISSUE.
module mem_access_unit #(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus,
  output logic [15:0]        acc_cnt,
  output logic               w_en,
  output logic               r_en,
  output logic [31:0]        addr,
  output logic [31:0]        Dato,
  input  logic [31:0]        resRAM
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic                req_ready;
  logic                req_ready_nx;
  logic                rsp_valid;
  logic                rsp_valid_nx;
  logic                rsp_err;
  logic                rsp_err_nx;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [DATA_W-1:0]   rsp_rdata_nx;
  logic [CNT_W-1:0]    acc_cnt_nx;
  logic                w_en_nx;
  logic                r_en_nx;
  logic [DATA_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   dato_nx;
  logic                req_bad_c;

  // Misaligned byte address or word index beyond the attached RAM.
  assign req_bad_c = (bus.req_addr[1:0] != 2'b00) ||
                     (DATA_W'(bus.req_addr[31:2]) >= DATA_W'(DEPTH));

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      acc_cnt   <= '0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
      Dato      <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= req_ready_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
      acc_cnt   <= acc_cnt_nx;
      w_en      <= w_en_nx;
      r_en      <= r_en_nx;
      addr      <= addr_nx;
      Dato      <= dato_nx;
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_nx     = state;
    rsp_valid_nx = rsp_valid;
    rsp_err_nx   = rsp_err;
    rsp_rdata_nx = rsp_rdata;
    acc_cnt_nx   = acc_cnt;
    w_en_nx      = 1'b0;
    r_en_nx      = 1'b0;
    addr_nx      = addr;
    dato_nx      = Dato;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad_c) begin
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_err_nx   = 1'b1;
            rsp_rdata_nx = '0;
          end else begin
            state_nx = ISSUE;
            w_en_nx  = bus.req_we;
            r_en_nx  = ~bus.req_we;
            addr_nx  = DATA_W'(bus.req_addr[31:2]);
            dato_nx  = bus.req_wdata;
          end
        end
      end
      ISSUE: begin
        // resRAM was refreshed on the falling edge inside this cycle.
        state_nx     = RESP;
        rsp_valid_nx = 1'b1;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = r_en ? resRAM : '0;
        acc_cnt_nx   = acc_cnt + CNT_W'(1);
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          rsp_err_nx   = 1'b0;
          rsp_rdata_nx = '0;
        end
      end
      default: begin
        state_nx     = IDLE;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
        rsp_rdata_nx = '0;
      end
    endcase

    req_ready_nx = (state_nx == IDLE);
  end

  a_no_rw_overlap: assert property (@(posedge clk) !(w_en && r_en));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural falling-edge RAM.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] acc_cnt;
  logic        w_en;
  logic        r_en;
  logic [31:0] addr;
  logic [31:0] Dato;
  logic [31:0] resRAM = '0;
  logic [31:0] mem [16] = '{default: 32'h0};
  int          overlap = 0;
  int          checks = 0;
  int          passed = 0;
  int          exp_cnt = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.DEPTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .acc_cnt(acc_cnt),
    .w_en   (w_en),
    .r_en   (r_en),
    .addr   (addr),
    .Dato   (Dato),
    .resRAM (resRAM)
  );

  always #5 clk = ~clk;

  // RAM model: write and read both take effect on the falling edge.
  always @(negedge clk) begin
    if (w_en && r_en) overlap = overlap + 1;
    if (w_en) mem[addr[3:0]] = Dato;
    if (r_en) resRAM = mem[addr[3:0]];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // One full transaction from IDLE back to IDLE, with checks along the way.
  task automatic run_req(input string tag, input vec_t v);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.a;
    bus.req_wdata = v.wdata;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    bus.req_we    = ~v.we;
    bus.req_addr  = 32'h0000_0004;
    bus.req_wdata = 32'h5555_AAAA;
    if (!v.err) begin
      chk({tag, " w_en"}, 32'(w_en), 32'(v.we));
      chk({tag, " r_en"}, 32'(r_en), 32'(!v.we));
      chk({tag, " addr"}, addr, {2'b00, v.a[31:2]});
      chk({tag, " Dato"}, Dato, v.wdata);
      chk({tag, " issue rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, " issue req_ready"}, 32'(bus.req_ready), 32'd0);
      tick();
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    chk({tag, " no ram access"}, 32'({w_en, r_en}), 32'd0);
    chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(v.err));
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
    chk({tag, " acc_cnt"}, 32'(acc_cnt), 32'(exp_cnt));
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk({tag, " held rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " held rsp_rdata"}, bus.rsp_rdata, v.rdata);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, " done rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " done req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  vec_t vecs[9];
  vec_t v;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    tick();

    // Reset state, with a request presented on the reset edge.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0008;
    bus.req_wdata = 32'h1234_5678;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b0;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset w_en/r_en", 32'({w_en, r_en}), 32'd0);
    chk("reset addr", addr, 32'd0);
    chk("reset Dato", Dato, 32'd0);
    chk("reset acc_cnt", 32'(acc_cnt), 32'd0);
    tick();
    chk("dropped req w_en", 32'(w_en), 32'd0);
    chk("dropped req rsp_valid", 32'(bus.rsp_valid), 32'd0);

    vecs[0] = '{1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0,         0};
    vecs[1] = '{1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'hDEAD_BEEF, 1};
    vecs[2] = '{1'b1, 32'h0000_0016, 32'h1111_2222, 1'b1, 32'h0,         0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h0,         2};
    vecs[4] = '{1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'h0,         0};
    vecs[5] = '{1'b1, 32'h0000_003C, 32'h1234_5678, 1'b0, 32'h0,         1};
    vecs[6] = '{1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'h1234_5678, 0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0,         0};
    vecs[8] = '{1'b1, 32'h0000_0001, 32'hABCD_0000, 1'b1, 32'h0,         1};
    for (int i = 0; i < 9; i++) run_req($sformatf("vec%0d", i), vecs[i]);

    // Back-pressure: response held, a new request ignored until IDLE.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0014;
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0008;
    bus.req_wdata = 32'h0000_0077;
    tick();
    exp_cnt++;
    for (int c = 0; c < 5; c++) begin
      chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("bp req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp no access", 32'({w_en, r_en}), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp release req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp release no access", 32'({w_en, r_en}), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp new req w_en", 32'(w_en), 32'd1);
    chk("bp new req addr", addr, 32'd2);
    tick();
    exp_cnt++;
    chk("bp new req acc_cnt", 32'(acc_cnt), 32'(exp_cnt));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Reset during ISSUE of a store: RAM still written, no response.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    bus.req_wdata = 32'hCAFE_F00D;
    tick();
    bus.req_valid = 1'b0;
    chk("rst-issue w_en", 32'(w_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rst-issue req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst-issue rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst-issue acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst-issue w_en", 32'(w_en), 32'd0);
    v = '{1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hCAFE_F00D, 0};
    run_req("rst-issue reload", v);

    // Reset during RESP discards the pending response.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0014;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rst-resp pending", 32'(bus.rsp_valid), 32'd1);
    do_reset();
    chk("rst-resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst-resp rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst-resp acc_cnt", 32'(acc_cnt), 32'd0);

    // Sweep every word: store then load back.
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 32'(i * 4), 32'(i) * 32'h1111_1111, 1'b0, 32'h0, 0};
      run_req($sformatf("sweep st%0d", i), v);
    end
    for (int i = 0; i < 16; i++) begin
      v = '{1'b0, 32'(i * 4), 32'h0, 1'b0, 32'(i) * 32'h1111_1111, 0};
      run_req($sformatf("sweep ld%0d", i), v);
    end
    chk("sweep acc_cnt", 32'(acc_cnt), 32'd32);
    chk("w_en/r_en overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DEPTH, 16, number of 32-bit words in the attached data RAM; word index range 0..DEPTH-1.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  processor load/store request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  processor accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was rejected: misaligned or out of range.
- acc_cnt  out  16  count of completed RAM accesses.
- w_en  out  1  RAM write enable.
- r_en  out  1  RAM read enable.
- addr  out  32  RAM word index.
- Dato  out  32  RAM write data.
- resRAM  in  32  RAM read data; the RAM updates it on the falling clk edge.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-004 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 A request SHALL be accepted on a rising edge when the state is IDLE and req_valid=1; req_we, req_addr and req_wdata are latched on that edge.
REQ-006 An accepted request SHALL be an error if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH.
REQ-007 An error request SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL NOT assert w_en or r_en.
REQ-008 A valid request SHALL go IDLE->ISSUE.
- addr = req_addr[31:2], zero-extended.
- Dato = req_wdata.
- Exactly one of r_en (load) or w_en (store) is high for exactly the ISSUE cycle.
REQ-009 w_en, r_en, addr and Dato SHALL be registered outputs, stable from the rising edge through the following falling edge.
REQ-010 w_en and r_en SHALL never be 1 in the same cycle; both SHALL be 0 outside ISSUE.
REQ-011 On the rising edge that leaves ISSUE:
- A load SHALL capture resRAM into rsp_rdata.
- A store SHALL set rsp_rdata=0.
- rsp_err=0 in both cases.
- The state becomes RESP.
REQ-012 Latency SHALL be fixed: for a valid request accepted at edge N, rsp_valid=1 from edge N+2; for an error request, from edge N+1.
REQ-013 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until a rising edge with rsp_ready=1, which returns the state to IDLE.
REQ-014 A new request SHALL be accepted no earlier than the edge after the RESP->IDLE transition; back-to-back throughput is one access per 3 cycles.
REQ-015 acc_cnt SHALL increment by 1 on each ISSUE->RESP transition; it wraps 0xFFFF->0x0000, and error requests do not count.
REQ-016 Changes to req_* inputs while the state is not IDLE SHALL have no effect.

Reset
REQ-017 On a rising edge with rst=1, the unit SHALL go to IDLE and set all of these to 0: rsp_valid, rsp_err, rsp_rdata, w_en, r_en, addr, Dato, acc_cnt.
REQ-018 rst SHALL take priority over acceptance: a request presented on a reset edge is dropped.
REQ-019 rst asserted while in ISSUE SHALL NOT suppress the RAM access already in progress (the falling edge has occurred); no response is produced and acc_cnt is cleared.
REQ-020 rst asserted in RESP SHALL discard the pending response.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Store: req_we=1, req_addr=0x0000_0014, req_wdata=0xDEAD_BEEF -> one cycle with w_en=1, addr=5, Dato=0xDEADBEEF; rsp_valid at N+2 with rsp_err=0, rsp_rdata=0; acc_cnt=1.
- Load back: req_addr=0x14, req_we=0 -> one cycle with r_en=1, addr=5; rsp_rdata=0xDEADBEEF at N+2.
- Errors: req_addr=0x0000_0016 (misaligned), then 0x0000_0040 (index 16) -> rsp_err=1 at N+1; w_en=r_en=0 throughout; acc_cnt unchanged.
- Back-pressure: rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata held constant; req_ready=0; a new req_valid is ignored until one cycle after rsp_ready=1.
- Reset in ISSUE: rst=1 during a store cycle -> next cycle has state IDLE, rsp_valid=0, acc_cnt=0; a later load of the same address returns the stored data.
- Sweep: store i*0x11111111 to word i for i=0..15, then load all 16 -> data matches; acc_cnt=32; w_en and r_en are never high together.
